// File: rtl/sequence_checker.sv
// Simon pattern store: appends LFSR-generated moves, replays them one per request,
// and checks the player's entries against the stored pattern.
module sequence_checker #(
  parameter int          MAX_ROUNDS = 32,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seq_clear,
  input  logic       seq_append,
  input  logic       play_next,
  output logic [3:0] play_move,
  output logic       play_done,
  input  logic       check_req,
  input  logic [3:0] player_input,
  output logic       result,
  output logic       result_valid,
  output logic       turn_done,
  output logic [5:0] current_round,
  output logic       full,
  output logic [1:0] state_dbg
);

  localparam logic [5:0] MAX_LEN = 6'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  len_q;
  logic [5:0]  idx_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [3:0]  play_move_q;
  logic        play_done_q;
  logic        result_q;
  logic        result_valid_q;
  logic        turn_done_q;
  logic [3:0]  mem_q [64];

  logic [3:0]  new_move;
  logic [3:0]  mem_rd;
  logic        full_w;
  logic        input_onehot;
  logic        match;
  logic        mem_we;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  assign lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign new_move     = 4'b0001 << lfsr_q[1:0];
  assign mem_rd       = mem_q[idx_q];
  assign full_w       = (len_q == MAX_LEN);
  assign input_onehot = (player_input != 4'd0) &&
                        ((player_input & (player_input - 4'd1)) == 4'd0);
  assign match        = input_onehot && (player_input == mem_rd);
  assign mem_we       = reset && !seq_clear && (state_q == S_IDLE) && seq_append && !full_w;

  // Pattern storage carries no reset; only entries below len_q are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[len_q] <= new_move;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_q          <= 6'd0;
      idx_q          <= 6'd0;
      lfsr_q         <= SEED;
      play_move_q    <= 4'd0;
      play_done_q    <= 1'b0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
      turn_done_q    <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      result_valid_q <= 1'b0;
      turn_done_q    <= 1'b0;
      if (seq_clear) begin
        state_q     <= S_IDLE;
        len_q       <= 6'd0;
        idx_q       <= 6'd0;
        play_move_q <= 4'd0;
        play_done_q <= 1'b0;
        result_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (seq_append && !full_w) begin
              len_q   <= len_q + 6'd1;
              idx_q   <= 6'd0;
              state_q <= S_PLAY;
            end
          end
          S_PLAY: begin
            // One extra play_next after the last move blanks the display and hands over to the player.
            if (play_next) begin
              if (idx_q < len_q) begin
                play_move_q <= mem_rd;
                idx_q       <= idx_q + 6'd1;
                play_done_q <= ((idx_q + 6'd1) == len_q);
              end else begin
                play_move_q <= 4'd0;
                play_done_q <= 1'b0;
                idx_q       <= 6'd0;
                state_q     <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (check_req) begin
              result_valid_q <= 1'b1;
              result_q       <= match;
              if (!match) begin
                state_q <= S_FAIL;
              end else if (idx_q == (len_q - 6'd1)) begin
                turn_done_q <= 1'b1;
                idx_q       <= 6'd0;
                state_q     <= S_IDLE;
              end else begin
                idx_q <= idx_q + 6'd1;
              end
            end
          end
          default: begin
            result_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign play_move     = play_move_q;
  assign play_done     = play_done_q;
  assign result        = result_q;
  assign result_valid  = result_valid_q;
  assign turn_done     = turn_done_q;
  assign current_round = len_q;
  assign full          = full_w;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: vector table for the main protocol, generated rounds up to
// a full pattern, and a hand-written asynchronous reset in the middle of a check turn.
module tb_sequence_checker;

  localparam int          MAX_ROUNDS = 32;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam logic [1:0]  ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_CHECK = 2'd2, ST_FL = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       seq_clear, seq_append, play_next, check_req;
  logic [3:0] player_input;
  logic [3:0] play_move;
  logic       play_done, result, result_valid, turn_done, full;
  logic [5:0] current_round;
  logic [1:0] state_dbg;

  sequence_checker #(.MAX_ROUNDS(MAX_ROUNDS), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .seq_clear(seq_clear), .seq_append(seq_append),
    .play_next(play_next), .play_move(play_move), .play_done(play_done),
    .check_req(check_req), .player_input(player_input), .result(result),
    .result_valid(result_valid), .turn_done(turn_done), .current_round(current_round),
    .full(full), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference LFSR straight from the polynomial definition.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    logic       clr, app, nxt, chk;
    logic [1:0] mode;   // 0: correct move, 1: literal pin, 2: wrong one-hot
    logic [3:0] pin;
    int         round;
    logic [1:0] st;
    logic       rv, res, td, pd;
  } vec_t;

  // scoreboard
  logic [3:0] exp_q[$];
  logic [3:0] m_mem[$];
  logic [3:0] exp_pm;
  int         chk_i, pl_i, prev_round;
  logic [1:0] prev_state;
  int         total = 0;
  int         bad   = 0;
  vec_t       tbl[$];

  function automatic vec_t mk(input logic clr, app, nxt, chk, input logic [1:0] mode,
                              input logic [3:0] pin, input int round, input logic [1:0] st,
                              input logic rv, res, td, pd);
    vec_t v;
    v.clr = clr; v.app = app; v.nxt = nxt; v.chk = chk; v.mode = mode; v.pin = pin;
    v.round = round; v.st = st; v.rv = rv; v.res = res; v.td = td; v.pd = pd;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // driver: one request cycle, outputs sampled 1ns after the active edge
  task automatic step(input vec_t v);
    logic [3:0] correct;
    logic       pushed;
    correct = (chk_i < m_mem.size()) ? m_mem[chk_i] : 4'd0;
    seq_clear  = v.clr;
    seq_append = v.app;
    play_next  = v.nxt;
    check_req  = v.chk;
    case (v.mode)
      2'd0:    player_input = correct;
      2'd1:    player_input = v.pin;
      default: player_input = {correct[2:0], correct[3]};
    endcase
    if (v.app && v.round > prev_round) m_mem.push_back(4'b0001 << m_lfsr[1:0]);
    pushed = 1'b0;
    if (v.nxt && prev_state == ST_PLAY && !v.clr) begin
      exp_q.push_back((pl_i < m_mem.size()) ? m_mem[pl_i] : 4'd0);
      pl_i++;
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pushed) exp_pm = exp_q.pop_front();
    if (v.clr) exp_pm = 4'd0;
    cmp("current_round", current_round, v.round);
    cmp("state", state_dbg, v.st);
    cmp("result_valid", result_valid, v.rv);
    cmp("result", result, v.res);
    cmp("turn_done", turn_done, v.td);
    cmp("play_done", play_done, v.pd);
    cmp("play_move", play_move, exp_pm);
    cmp("full", full, (v.round == MAX_ROUNDS) ? 1 : 0);
    if (prev_state == ST_CHECK && v.chk && v.res) chk_i++;
    if (v.st != ST_CHECK) chk_i = 0;
    if (v.st != ST_PLAY) pl_i = 0;
    if (v.clr) m_mem.delete();
    prev_state = v.st;
    prev_round = v.round;
    seq_clear = 0; seq_append = 0; play_next = 0; check_req = 0; player_input = 4'd0;
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_round"}, current_round, 0);
    cmp({tag, "_state"}, state_dbg, ST_IDLE);
    cmp({tag, "_play_move"}, play_move, 0);
    cmp({tag, "_play_done"}, play_done, 0);
    cmp({tag, "_result"}, result, 0);
    cmp({tag, "_result_valid"}, result_valid, 0);
    cmp({tag, "_turn_done"}, turn_done, 0);
    cmp({tag, "_full"}, full, 0);
  endtask

  task automatic model_reset();
    m_mem.delete(); exp_q.delete();
    exp_pm = 4'd0; chk_i = 0; pl_i = 0; prev_round = 0; prev_state = ST_IDLE;
  endtask

  initial begin
    reset = 1'b0;
    seq_clear = 0; seq_append = 0; play_next = 0; check_req = 0; player_input = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    // clr app nxt chk mode pin round state rv res td pd
    tbl.push_back(mk(0,1,0,0,0,4'd0,1,ST_PLAY ,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,4'd0,1,ST_PLAY ,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_PLAY ,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,4'd0,1,ST_PLAY ,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_CHECK,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_CHECK,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,4'd0,1,ST_IDLE ,1,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,4'd0,1,ST_IDLE ,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,4'd0,1,ST_IDLE ,0,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'd0,2,ST_PLAY ,0,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'd0,2,ST_PLAY ,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,2,ST_PLAY ,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,2,ST_PLAY ,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'd0,2,ST_CHECK,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,4'd0,2,ST_CHECK,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,4'd0,2,ST_IDLE ,1,1,1,0));
    tbl.push_back(mk(0,1,0,0,0,4'd0,3,ST_PLAY ,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,3,ST_PLAY ,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,3,ST_PLAY ,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,3,ST_PLAY ,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'd0,3,ST_CHECK,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,4'd0,3,ST_CHECK,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,1,4'b0110,3,ST_FL,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,4'd0,3,ST_FL   ,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'd0,3,ST_FL   ,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,3,ST_FL   ,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,4'd0,0,ST_IDLE ,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'd0,1,ST_PLAY ,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_PLAY ,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,4'd0,0,ST_IDLE ,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'd0,1,ST_PLAY ,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_PLAY ,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_CHECK,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,4'b0000,1,ST_FL,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,4'd0,0,ST_IDLE ,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,4'd0,1,ST_PLAY ,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_PLAY ,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'd0,1,ST_CHECK,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,2,4'd0,1,ST_FL   ,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,4'd0,0,ST_IDLE ,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
      // first move after reset release comes from SEED[1:0] = 2'b01
      if (i == 2) cmp("first_move", play_move, 4'b0010);
    end

    // Build the pattern to full length, completing every round correctly.
    for (int r = 1; r <= MAX_ROUNDS; r++) begin
      step(mk(0,1,0,0,0,4'd0,r,ST_PLAY,0,(r > 1),0,0));
      for (int k = 1; k <= r + 1; k++)
        step(mk(0,0,1,0,0,4'd0,r,(k == r + 1) ? ST_CHECK : ST_PLAY,0,(r > 1),0,(k == r)));
      for (int k = 1; k <= r; k++)
        step(mk(0,0,0,1,0,4'd0,r,(k == r) ? ST_IDLE : ST_CHECK,1,1,(k == r),0));
    end
    step(mk(0,1,0,0,0,4'd0,MAX_ROUNDS,ST_IDLE,0,1,0,0));

    // Asynchronous reset in the middle of a check turn.
    step(mk(1,0,0,0,0,4'd0,0,ST_IDLE ,0,0,0,0));
    step(mk(0,1,0,0,0,4'd0,1,ST_PLAY ,0,0,0,0));
    step(mk(0,0,1,0,0,4'd0,1,ST_PLAY ,0,0,0,1));
    step(mk(0,0,1,0,0,4'd0,1,ST_CHECK,0,0,0,0));
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(mk(0,1,0,0,0,4'd0,1,ST_PLAY,0,0,0,0));
    step(mk(0,0,1,0,0,4'd0,1,ST_PLAY,0,0,0,1));
    cmp("reseeded_move", play_move, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
